// File: rtl/spi_reg_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_slave_pkg
// Shared definitions for the SPI register responder:
//   - frame field positions for the 32-bit frame
//       {rw[31], addr[30:28], rsvd[27:16], data[15:0]}
//   - FSM state encoding
// -----------------------------------------------------------------------------
package spi_reg_slave_pkg;

    localparam int RW_BIT   = 31;
    localparam int ADDR_MSB = 30;
    localparam int ADDR_LSB = 28;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Brings one asynchronous pad signal into the osc_clk domain through a
// STAGES-deep flop chain, then compares against one extra flop to produce
// single-cycle rise/fall pulses aligned with the synchronized level.
// Ports:
//   osc_clk  in   system clock
//   rst_n    in   synchronous active-low reset (chain clears to 0)
//   din      in   asynchronous pad input
//   level    out  synchronized level
//   rise     out  1-cycle pulse on synchronized 0->1
//   fall     out  1-cycle pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic osc_clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Clearing to 0 matters for SSEL: the responder must actually observe a
    // synchronized high before it will accept a frame after reset.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = sync_reg[STAGES-1] & ~prev_reg;
    assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
// SPI mode-0, MSB-first responder running entirely on osc_clk. Pads are
// oversampled; 32-bit write frames update a NUM_REGS x REG_W register file,
// and each frame shifts a caller-supplied word (tx_data) out on MISO.
// Frame: {rw[31], addr[30:28], rsvd[27:16], data[15:0]}.
// Ports:
//   osc_clk    in   system clock (SCK <= osc_clk/8)
//   rst_n      in   synchronous active-low reset
//   SCK/SSEL   in   SPI clock / active-low select (async pads)
//   MOSI       in   serial data in
//   MISO       out  serial data out, 0 outside a frame
//   tx_data    in   word returned in a frame, latched at frame start
//   tx_ack     out  1-cycle pulse when tx_data is latched
//   Registers  out  flat register file, reg n at [n*REG_W +: REG_W]
//   wr_strobe  out  1-cycle pulse on register write
//   wr_addr    out  address of last write
//   frame_err  out  1-cycle pulse when a frame ends with bit count != FRAME_BITS
// Optional build macro: SPI_SLAVE_READBACK_EN
//   A valid read frame (rw=0) schedules {0, Registers[addr]} as the MISO word
//   of the next frame in place of tx_data (tx_ack not pulsed). An errored
//   frame leaves the pending readback in place for the following frame.
// -----------------------------------------------------------------------------
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int FRAME_BITS  = 32,
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      osc_clk,
    input  logic                      rst_n,
    input  logic                      SCK,
    input  logic                      SSEL,
    input  logic                      MOSI,
    output logic                      MISO,
    input  logic [FRAME_BITS-1:0]     tx_data,
    output logic                      tx_ack,
    output logic [NUM_REGS*REG_W-1:0] Registers,
    output logic                      wr_strobe,
    output logic [2:0]                wr_addr,
    output logic                      frame_err
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    // ---------------------------------------------------------------- sync
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic mosi_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .osc_clk (osc_clk),
        .rst_n   (rst_n),
        .din     (SCK),
        .level   (sck_lvl_unused),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ssel_sync (
        .osc_clk (osc_clk),
        .rst_n   (rst_n),
        .din     (SSEL),
        .level   (ssel_lvl),
        .rise    (ssel_rise),
        .fall    (ssel_fall)
    );

    // MOSI goes through the same depth as SCK so the sampled bit lines up
    // with the synchronized SCK rise pulse.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // ---------------------------------------------------------------- state
    spi_state_t             state_reg, state_next;
    logic                   armed_reg;
    logic                   start_frame;
    logic [FRAME_BITS-1:0]  rx_reg;
    logic [FRAME_BITS-1:0]  tx_sr_reg;
    logic                   miso_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic                   tx_ack_reg, wr_strobe_reg, frame_err_reg;
    logic [2:0]             wr_addr_reg;
    logic [REG_W-1:0]       regs_reg [NUM_REGS];

    logic                   frame_ok;
    logic                   wr_en;
    logic [2:0]             rx_addr;
    logic [FRAME_BITS-1:0]  load_word;
    logic                   load_ack;
    logic                   rsvd_unused;

    assign rx_addr     = rx_reg[ADDR_MSB:ADDR_LSB];
    assign frame_ok    = (bit_cnt_reg == CNT_FULL);
    assign wr_en       = (state_reg == ST_COMMIT) && frame_ok && rx_reg[RW_BIT];
    assign rsvd_unused = ^rx_reg[ADDR_LSB-1:DATA_MSB+1];

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ssel_fall && armed_reg) begin
                    state_next  = ST_SHIFT;
                    start_frame = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ssel_rise) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // A frame already in progress when reset releases must not be decoded,
    // so arming waits for a genuine synchronized SSEL high.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            armed_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && ssel_lvl) begin
            armed_reg <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            rx_reg        <= '0;
            tx_sr_reg     <= '0;
            miso_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            tx_ack_reg    <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            tx_ack_reg    <= 1'b0;
            wr_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            if (start_frame) begin
                // MSB is presented immediately; the rest waits for SCK falls.
                miso_reg    <= load_word[FRAME_BITS-1];
                tx_sr_reg   <= {load_word[FRAME_BITS-2:0], 1'b0};
                bit_cnt_reg <= '0;
                tx_ack_reg  <= load_ack;
            end else if (state_reg == ST_SHIFT && !ssel_rise) begin
                // SSEL rise takes priority: an SCK edge in the same cycle is dropped.
                if (sck_rise) begin
                    rx_reg <= {rx_reg[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt_reg != CNT_SAT) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                if (sck_fall) begin
                    miso_reg  <= tx_sr_reg[FRAME_BITS-1];
                    tx_sr_reg <= {tx_sr_reg[FRAME_BITS-2:0], 1'b0};
                end
            end else if (state_reg == ST_COMMIT) begin
                if (!frame_ok) begin
                    frame_err_reg <= 1'b1;
                end else if (rx_reg[RW_BIT]) begin
                    wr_strobe_reg <= 1'b1;
                    wr_addr_reg   <= rx_addr;
                end
            end
        end
    end

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[rx_addr] <= rx_reg[DATA_MSB:DATA_LSB];
        end
    end

    // ---------------------------------------------------------------- readback
`ifdef SPI_SLAVE_READBACK_EN
    logic       rd_pending_reg;
    logic       rb_active_reg;
    logic [2:0] rd_addr_reg;

    always_comb begin
        load_word = tx_data;
        load_ack  = 1'b1;
        if (rd_pending_reg) begin
            load_word = {{(FRAME_BITS-REG_W){1'b0}}, regs_reg[rd_addr_reg]};
            load_ack  = 1'b0;
        end
    end

    // The pending readback is consumed only by a frame that completes
    // cleanly; a back-to-back read frame re-arms it with its own address.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            rd_pending_reg <= 1'b0;
            rb_active_reg  <= 1'b0;
            rd_addr_reg    <= '0;
        end else begin
            if (start_frame) begin
                rb_active_reg <= rd_pending_reg;
            end
            if (state_reg == ST_COMMIT && frame_ok) begin
                if (rb_active_reg) begin
                    rd_pending_reg <= 1'b0;
                end
                if (!rx_reg[RW_BIT]) begin
                    rd_pending_reg <= 1'b1;
                    rd_addr_reg    <= rx_addr;
                end
            end
        end
    end
`else
    always_comb begin
        load_word = tx_data;
        load_ack  = 1'b1;
    end
`endif

    // ---------------------------------------------------------------- outputs
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign Registers[gi*REG_W +: REG_W] = regs_reg[gi];
        end
    endgenerate

    assign MISO      = (state_reg == ST_SHIFT) & miso_reg;
    assign tx_ack    = tx_ack_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;

endmodule
